// File: rtl/exe_div_sequencer.sv
// Multi-cycle RV64M divide/remainder unit that sits beside the single-cycle EXE ALU.
// Radix-2 restoring divider (one quotient bit per cycle) with early exit for divide-by-zero and signed overflow.
module exe_div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [1:0]      OP,
  input  logic            W,
  input  logic [XLEN-1:0] SRC1,
  input  logic [XLEN-1:0] SRC2,
  output logic            BUSY,
  output logic            STALL_REQ,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return (~v) + 64'd1;
  endfunction

  // Word forms use only the low half, extended according to the signedness of the op.
  function automatic logic [63:0] extend_operand(input logic [63:0] v, input logic w, input logic is_signed);
    logic [63:0] res;
    if (w && is_signed) begin
      res = sext32(v[31:0]);
    end else if (w) begin
      res = {32'd0, v[31:0]};
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Word results are sign-extended from bit 31 for every op, unsigned ones included.
  function automatic logic [63:0] finalize(input logic [63:0] sel, input logic w);
    logic [63:0] res;
    if (w) begin
      res = sext32(sel[31:0]);
    end else begin
      res = sel;
    end
    return res;
  endfunction

  state_t      state_r;
  logic [1:0]  op_r;
  logic        w_r;
  logic [63:0] a_r;
  logic [63:0] b_r;
  logic [63:0] rem_r;
  logic [63:0] quo_r;
  logic [63:0] div_r;
  logic        q_neg_r;
  logic        r_neg_r;
  logic [6:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic [63:0] result_r;

  logic        accept_s;
  logic [63:0] src1_ext_s;
  logic [63:0] src2_ext_s;
  logic        is_signed_s;
  logic        sign1_s;
  logic        sign2_s;
  logic [63:0] mag_a_s;
  logic [63:0] mag_b_s;
  logic [63:0] min_val_s;
  logic        div_zero_s;
  logic        ovf_s;
  logic        special_s;
  logic [63:0] special_q_s;
  logic [63:0] special_r_s;
  logic [63:0] special_val_s;
  logic [64:0] rem_sh_s;
  logic [64:0] diff_s;
  logic        keep_s;
  logic [63:0] q_fix_s;
  logic [63:0] r_fix_s;
  logic [63:0] fix_val_s;

  // Request acceptance: only from IDLE or DONE, and a flush in the same cycle wins.
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == S_IDLE || state_r == S_DONE) && START && !FLUSH) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    src1_ext_s = extend_operand(SRC1, W, ~OP[0]);
    src2_ext_s = extend_operand(SRC2, W, ~OP[0]);
  end

  // Operand magnitudes, result signs and early-out detection for the PREP cycle.
  always_comb begin
    is_signed_s = ~op_r[0];
    sign1_s     = is_signed_s & a_r[63];
    sign2_s     = is_signed_s & b_r[63];
    mag_a_s     = a_r;
    mag_b_s     = b_r;
    if (sign1_s) begin
      mag_a_s = neg64(a_r);
    end else begin
      mag_a_s = a_r;
    end
    if (sign2_s) begin
      mag_b_s = neg64(b_r);
    end else begin
      mag_b_s = b_r;
    end
    if (w_r) begin
      min_val_s = 64'hFFFF_FFFF_8000_0000;
    end else begin
      min_val_s = 64'h8000_0000_0000_0000;
    end
    div_zero_s = (b_r == 64'd0);
    ovf_s      = is_signed_s && (a_r == min_val_s) && (b_r == 64'hFFFF_FFFF_FFFF_FFFF);
    special_s  = div_zero_s | ovf_s;
    special_q_s = a_r;
    special_r_s = 64'd0;
    if (div_zero_s) begin
      special_q_s = 64'hFFFF_FFFF_FFFF_FFFF;
      special_r_s = a_r;
    end else begin
      special_q_s = a_r;
      special_r_s = 64'd0;
    end
    if (op_r[1]) begin
      special_val_s = finalize(special_r_s, w_r);
    end else begin
      special_val_s = finalize(special_q_s, w_r);
    end
  end

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor magnitude.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[63]};
    diff_s   = rem_sh_s - {1'b0, div_r};
    keep_s   = ~diff_s[64];
  end

  // Sign correction and final selection for the FIX cycle.
  always_comb begin
    q_fix_s = quo_r;
    r_fix_s = rem_r;
    if (q_neg_r) begin
      q_fix_s = neg64(quo_r);
    end else begin
      q_fix_s = quo_r;
    end
    if (r_neg_r) begin
      r_fix_s = neg64(rem_r);
    end else begin
      r_fix_s = rem_r;
    end
    if (op_r[1]) begin
      fix_val_s = finalize(r_fix_s, w_r);
    end else begin
      fix_val_s = finalize(q_fix_s, w_r);
    end
  end

  // Sequencing FSM with datapath registers and registered BUSY/DONE/RESULT.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= S_IDLE;
      op_r     <= 2'd0;
      w_r      <= 1'b0;
      a_r      <= 64'd0;
      b_r      <= 64'd0;
      rem_r    <= 64'd0;
      quo_r    <= 64'd0;
      div_r    <= 64'd0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      cnt_r    <= 7'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 64'd0;
    end else if (FLUSH) begin
      state_r <= S_IDLE;
      cnt_r   <= 7'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            op_r    <= OP;
            w_r     <= W;
            a_r     <= src1_ext_s;
            b_r     <= src2_ext_s;
            busy_r  <= 1'b1;
            state_r <= S_PREP;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_PREP: begin
          if (special_s) begin
            result_r <= special_val_s;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            rem_r   <= 64'd0;
            // Word dividends sit in the upper half so 32 shifts consume them completely.
            quo_r   <= w_r ? {mag_a_s[31:0], 32'd0} : mag_a_s;
            div_r   <= mag_b_s;
            q_neg_r <= sign1_s ^ sign2_s;
            r_neg_r <= sign1_s;
            cnt_r   <= w_r ? 7'd32 : 7'd64;
            state_r <= S_ITER;
          end
        end
        S_ITER: begin
          rem_r <= keep_s ? diff_s[63:0] : rem_sh_s[63:0];
          quo_r <= {quo_r[62:0], keep_s};
          cnt_r <= cnt_r - 7'd1;
          if (cnt_r == 7'd1) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_ITER;
          end
        end
        S_FIX: begin
          result_r <= fix_val_s;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= S_DONE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= 7'd0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign RESULT    = result_r;
  assign STALL_REQ = accept_s | busy_r;

endmodule

// File: doc/exe_div_sequencer.md
# exe_div_sequencer

Multi-cycle integer divide/remainder unit with its own sequencing FSM, attached beside the single-cycle EXE ALU. It takes RV64M DIV/DIVU/REM/REMU and their W forms, holds EXE via a stall request while it iterates (radix-2 restoring, one quotient bit per cycle), and returns a 64-bit result for the EXE→MEM result mux. It implements the RISC-V divide-by-zero and signed-overflow results directly, so those cases finish early.

## Interface
- XLEN, 64, operand/result width; only 64 is supported.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request; sampled only in IDLE or DONE; EXE drives it as EXE_V && divide op.
- FLUSH  in  1  synchronous cancel from the context switch / pipeline flush.
- OP  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- W  in  1  1 = 32-bit word form (DIVW/DIVUW/REMW/REMUW).
- SRC1  in  64  dividend.
- SRC2  in  64  divisor.
- BUSY  out  1  high in PREP, ITER and FIX.
- STALL_REQ  out  1  combinational START_accepted | BUSY; freezes the fetch/decode/EXE latches.
- DONE  out  1  one-cycle pulse; RESULT is valid in this cycle.
- RESULT  out  64  quotient or remainder; held until the next accepted START.

## Operation
- States and transitions:
  - IDLE: START goes to PREP.
  - PREP: special case goes to DONE; otherwise goes to ITER.
  - ITER: stays for N cycles (N=64, or 32 when W=1), then goes to FIX.
  - FIX: goes to DONE.
  - DONE: START goes to PREP; otherwise goes to IDLE.
- Capture at accept: OP, W, SRC1, SRC2 are latched. They are not sampled again.
- W=1: operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops. The 32-bit result is sign-extended to 64 for all four ops, unsigned included.
- PREP:
  - Signed ops: take the magnitude of each operand. Record quotient sign = sign1 XOR sign2 and remainder sign = sign1.
  - Detect special cases.
- Special cases (width = 32 if W, else 64):
  - Divisor zero: quotient is all-ones (-1); remainder is the dividend, after the W extension.
  - Signed overflow, dividend = -2^(width-1) and divisor = -1: quotient is the dividend; remainder is 0.
- ITER: each cycle, shift the {rem, quo} pair left by 1 and trial-subtract the divisor. If the difference is non-negative, keep it and set the quotient bit. An internal counter counts N down to 0.
- FIX:
  - Negate the quotient if its recorded sign is negative (signed ops only).
  - Negate the remainder if its recorded sign is negative (signed ops only).
  - Select quotient or remainder by OP[1]; apply the W sign-extension; register into RESULT.
- FLUSH: any state goes to IDLE on the next edge. DONE is not pulsed and RESULT is not updated. FLUSH has priority over a simultaneous START.
- START while BUSY: ignored; the request is not queued.

## Timing
- Reset (RESET_N low, asynchronous): state IDLE; BUSY 0, DONE 0, STALL_REQ 0 (with START low), RESULT 0, counter 0.
- Reset asserted mid-operation aborts immediately with no DONE. The first START after release starts a fresh operation.
- Cycle numbering: START sampled at edge 0.
  - PREP is cycle 1.
  - ITER is cycles 2..N+1.
  - FIX is cycle N+2.
  - DONE is cycle N+3: 67 for 64-bit, 35 for W.
  - A special case pulses DONE in cycle 2.
- STALL_REQ: high in cycle 0 combinationally from START, then through the last BUSY cycle. It is low in the DONE cycle, so EXE advances with RESULT in that cycle.
- Back-to-back: START in the DONE cycle goes to PREP at the next edge; there is no idle bubble.

## Test plan
- DIV, SRC1=-7, SRC2=2 → DONE at cycle 67, RESULT 0xFFFF_FFFF_FFFF_FFFD; repeat as REM → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU, SRC2=0, SRC1=5 → DONE at cycle 2, RESULT 0xFFFF_FFFF_FFFF_FFFF; REMU with the same operands → 5.
- DIV, SRC1=0x8000_0000_0000_0000, SRC2=-1 → cycle 2, RESULT 0x8000_0000_0000_0000; REM → 0.
- DIVW, SRC1=0x0000_0000_8000_0000, SRC2=0xFFFF_FFFF → cycle 2, RESULT 0xFFFF_FFFF_8000_0000.
- REMUW, SRC1=0x1_0000_0007, SRC2=3 → DONE at cycle 35, RESULT 1.
- Cancellation and back-to-back:
  - FLUSH at cycle 10 with START also high → BUSY 0 at cycle 11 and no DONE pulse.
  - RESET_N low at cycle 20 → outputs zero immediately.
  - Back-to-back START in the DONE cycle → second DONE exactly N+3 cycles later.
